// File: rtl/decode_writeback.sv
// Y86-64 SEQ decode/write-back stage: operand decode, 15x64 register file and
// sticky processor status that blocks all writes once the machine stops.
module decode_writeback #(
   parameter logic [3:0] RNONE = 4'hF,
   parameter logic [3:0] RSP   = 4'h4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wb_valid,
   input  logic [3:0]  icode,
   input  logic [3:0]  rA,
   input  logic [3:0]  rB,
   input  logic        cnd,
   input  logic        instr_invalid,
   input  logic        mem_invalid,
   input  logic [63:0] val_e,
   input  logic [63:0] val_m,
   output logic [3:0]  src_a,
   output logic [3:0]  src_b,
   output logic [63:0] val_a,
   output logic [63:0] val_b,
   output logic [1:0]  stat,
   output logic        halted,
   input  logic [3:0]  dbg_sel,
   output logic [63:0] dbg_data
);

   localparam int unsigned XLEN     = 64;
   localparam int unsigned NREG     = 15;
   localparam logic [3:0]  ID_ZERO  = 4'hF;
   localparam logic [3:0]  ICODE_MAX = 4'hB;

   typedef enum logic [1:0] {
      STAT_AOK = 2'd0,
      STAT_HLT = 2'd1,
      STAT_ADR = 2'd2,
      STAT_INS = 2'd3
   } stat_e;

   logic [XLEN-1:0] regs_q [NREG];
   logic [XLEN-1:0] regs_d [NREG];
   stat_e           stat_q, stat_d;
   logic            halted_q, halted_d;
   logic [3:0]      dst_e, dst_m;
   logic            commit;

   // Register IDs from icode; cmovXX only targets rB when the condition held.
   always_comb begin
      src_a = RNONE;
      src_b = RNONE;
      dst_e = RNONE;
      dst_m = RNONE;
      case (icode)
         4'h2: begin src_a = rA; if (cnd) dst_e = rB; end
         4'h3: dst_e = rB;
         4'h4: begin src_a = rA; src_b = rB; end
         4'h5: begin src_b = rB; dst_m = rA; end
         4'h6: begin src_a = rA; src_b = rB; dst_e = rB; end
         4'h8: begin src_b = RSP; dst_e = RSP; end
         4'h9: begin src_a = RSP; src_b = RSP; dst_e = RSP; end
         4'hA: begin src_a = rA; src_b = RSP; dst_e = RSP; end
         4'hB: begin src_a = RSP; src_b = RSP; dst_e = RSP; dst_m = rA; end
         default: ;
      endcase
   end

   assign val_a    = (src_a   == ID_ZERO) ? '0 : regs_q[src_a];
   assign val_b    = (src_b   == ID_ZERO) ? '0 : regs_q[src_b];
   assign dbg_data = (dbg_sel == ID_ZERO) ? '0 : regs_q[dbg_sel];

   assign commit = wb_valid && (stat_q == STAT_AOK) && !instr_invalid &&
                   !mem_invalid && (icode <= ICODE_MAX);

   // M-port write comes second so popq %rsp keeps the loaded value.
   always_comb begin
      regs_d = regs_q;
      stat_d = stat_q;
      if (commit) begin
         if (dst_e != RNONE && dst_e != ID_ZERO) regs_d[dst_e] = val_e;
         if (dst_m != RNONE && dst_m != ID_ZERO) regs_d[dst_m] = val_m;
         if (icode == 4'h0) stat_d = STAT_HLT;
      end else if (wb_valid && stat_q == STAT_AOK) begin
         if (instr_invalid || icode > ICODE_MAX) stat_d = STAT_INS;
         else if (mem_invalid)                   stat_d = STAT_ADR;
      end
      halted_d = (stat_d != STAT_AOK);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
         stat_q   <= STAT_AOK;
         halted_q <= 1'b0;
      end else begin
         regs_q   <= regs_d;
         stat_q   <= stat_d;
         halted_q <= halted_d;
      end
   end

   assign stat   = stat_q;
   assign halted = halted_q;

endmodule
